// File: rtl/dqn_train_sequencer.sv
// Purpose: steps a DQN training datapath through LAST_PHASE phases per step for num_steps steps, captures the bias gradient.
// Latency: every control output is registered; a decision made at one rising edge shows up on the outputs right after that edge.
// Backpressure: phase_done gates each phase advance; a phase stalled for TIMEOUT cycles parks the block in ERR until start.
//
// Ports:
//   clk, rst        rising-edge clock; asynchronous active-high reset
//   start           one-cycle run request (accepted only in IDLE; in ERR it only clears the error)
//   abort           cancels a run in progress; ignored when not running
//   num_steps       steps per run, latched on an accepted start (0 = finish immediately)
//   phase_done      datapath acknowledgement that the current phase is complete
//   delta           Q6.10 output-layer error, captured at CAPTURE_PHASE
//   step            current step index (0 when idle)
//   controller      current phase code (0 when idle)
//   deltab          Q6.10 bias gradient = delta >>> 5, held between captures
//   busy            high while a run is in progress
//   done            one-cycle completion pulse
//   err             sticky phase-timeout flag
module dqn_train_sequencer #(
   parameter int LAST_PHASE    = 11,
   parameter int CAPTURE_PHASE = 9,
   parameter int TIMEOUT       = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic [3:0]         num_steps,
   input  logic               phase_done,
   input  logic signed [15:0] delta,
   output logic [3:0]         step,
   output logic [3:0]         controller,
   output logic signed [15:0] deltab,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   // The stall that would bring the timer up to TIMEOUT is the one that trips the error.
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
   localparam logic [3:0]    LAST = 4'(LAST_PHASE);
   localparam logic [3:0]    CAPT = 4'(CAPTURE_PHASE);

   typedef enum logic [1:0] {IDLE, RUN, FIN, ERR} state_t;

   state_t             state, state_n;
   logic [3:0]         nsteps, nsteps_n;
   logic [3:0]         step_n, ctrl_n;
   logic signed [15:0] deltab_n;
   logic               busy_n, done_n, err_n;
   logic [TW-1:0]      timer, timer_n;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         nsteps     <= '0;
         step       <= '0;
         controller <= '0;
         deltab     <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         timer      <= '0;
      end else begin
         state      <= state_n;
         nsteps     <= nsteps_n;
         step       <= step_n;
         controller <= ctrl_n;
         deltab     <= deltab_n;
         busy       <= busy_n;
         done       <= done_n;
         err        <= err_n;
         timer      <= timer_n;
      end
   end

   always_comb begin
      state_n  = state;
      nsteps_n = nsteps;
      step_n   = step;
      ctrl_n   = controller;
      deltab_n = deltab;
      busy_n   = busy;
      done_n   = 1'b0;
      err_n    = err;
      timer_n  = timer;

      case (state)
         IDLE: begin
            if (start) begin
               if (num_steps != 4'd0) begin
                  state_n  = RUN;
                  nsteps_n = num_steps;
                  step_n   = 4'd1;
                  ctrl_n   = 4'd1;
                  busy_n   = 1'b1;
                  timer_n  = '0;
               end else begin
                  // Empty run: skip straight to the completion pulse.
                  state_n = FIN;
                  done_n  = 1'b1;
               end
            end
         end

         RUN: begin
            if (abort) begin
               // Abort wins over a simultaneous phase_done, so no capture either.
               state_n = IDLE;
               step_n  = 4'd0;
               ctrl_n  = 4'd0;
               busy_n  = 1'b0;
               timer_n = '0;
            end else if (phase_done) begin
               timer_n = '0;
               if (controller == CAPT) begin
                  deltab_n = delta >>> 5;
               end
               if (controller < LAST) begin
                  ctrl_n = controller + 4'd1;
               end else if (step < nsteps) begin
                  step_n = step + 4'd1;
                  ctrl_n = 4'd1;
               end else begin
                  state_n = FIN;
                  step_n  = 4'd0;
                  ctrl_n  = 4'd0;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
               end
            end else if (timer == TMAX) begin
               // step/controller keep the failing position for debug.
               state_n = ERR;
               err_n   = 1'b1;
               busy_n  = 1'b0;
               timer_n = '0;
            end else begin
               timer_n = timer + 1'b1;
            end
         end

         FIN: begin
            state_n = IDLE;
         end

         ERR: begin
            if (start) begin
               state_n = IDLE;
               err_n   = 1'b0;
               step_n  = 4'd0;
               ctrl_n  = 4'd0;
            end
         end

         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule
